// File: rtl/vector_rasterizer_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_rasterizer_if
// Brief    : Line-queue and pixel-request bundle for the vector rasterizer.
// Revision : 1.0 - initial release
// ============================================================================
interface vector_rasterizer_if;
  // Queue head: combinational from the line-register queue
  logic signed [12:0] qStartX;
  logic signed [12:0] qEndX;
  logic signed [12:0] qStartY;
  logic signed [12:0] qEndY;
  logic        [3:0]  qIntensity;
  logic               qEmpty;
  logic               qRead;

  // Pixel write request towards the frame-buffer writer
  logic        [9:0]  pixX;
  logic        [9:0]  pixY;
  logic        [3:0]  pixIntensity;
  logic               pixValid;
  logic               pixReady;

  logic               busy;
  logic        [15:0] linesDone;

  modport master (
    input  qStartX, qEndX, qStartY, qEndY, qIntensity, qEmpty, pixReady,
    output qRead, pixX, pixY, pixIntensity, pixValid, busy, linesDone
  );

  modport slave (
    output qStartX, qEndX, qStartY, qEndY, qIntensity, qEmpty, pixReady,
    input  qRead, pixX, pixY, pixIntensity, pixValid, busy, linesDone
  );
endinterface
`default_nettype wire

// File: rtl/vector_rasterizer.sv
`default_nettype none
// ============================================================================
// Module   : vector_rasterizer
// Brief    : Pops AVG line segments and walks them with Bresenham into
//            clipped single-pixel write requests (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
module vector_rasterizer #(
  parameter int HRES = 640,
  parameter int VRES = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  vector_rasterizer_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_DRAW  = 2'd2
  } state_t;

  localparam logic signed [15:0] c_HALF_W = 16'(HRES / 2);
  localparam logic signed [15:0] c_TOP_Y  = 16'(VRES / 2 - 1);
  localparam logic signed [15:0] c_HRES   = 16'(HRES);
  localparam logic signed [15:0] c_VRES   = 16'(VRES);

  state_t             r_state;
  state_t             w_state_next;

  logic signed [15:0] r_x;
  logic signed [15:0] r_y;
  logic signed [15:0] r_x1;
  logic signed [15:0] r_y1;
  logic signed [15:0] r_dx;
  logic signed [15:0] r_dy;
  logic signed [15:0] r_err;
  logic               r_sx_neg;
  logic               r_sy_neg;
  logic        [3:0]  r_intensity;
  logic        [15:0] r_lines_done;

  logic               w_pop;
  logic               w_line_done;
  logic               w_visible;
  logic               w_pix_valid;
  logic               w_advance;
  logic               w_at_end;
  logic               w_step_x;
  logic               w_step_y;
  logic signed [15:0] w_raster_x;
  logic signed [15:0] w_raster_y;
  logic signed [15:0] w_diff_x;
  logic signed [15:0] w_diff_y;
  logic signed [15:0] w_abs_x;
  logic signed [15:0] w_abs_y;
  logic signed [15:0] w_err_next;
  logic signed [16:0] w_e2;

  // Pop only from IDLE; reset suppresses the pop so a segment is never half-taken.
  assign w_pop = (r_state == S_IDLE) && !bus.qEmpty && !rst;

  assign w_raster_x = r_x + c_HALF_W;
  assign w_raster_y = c_TOP_Y - r_y;
  assign w_visible  = (w_raster_x >= 16'sd0) && (w_raster_x < c_HRES) &&
                      (w_raster_y >= 16'sd0) && (w_raster_y < c_VRES);

  assign w_pix_valid = (r_state == S_DRAW) && w_visible;
  assign w_advance   = (r_state == S_DRAW) && (!w_visible || bus.pixReady);
  assign w_at_end    = (r_x == r_x1) && (r_y == r_y1);

  assign w_diff_x = r_x1 - r_x;
  assign w_diff_y = r_y1 - r_y;
  assign w_abs_x  = w_diff_x[15] ? -w_diff_x : w_diff_x;
  assign w_abs_y  = w_diff_y[15] ? -w_diff_y : w_diff_y;

  // Both step decisions look at the pre-step error term.
  assign w_e2       = {r_err, 1'b0};
  assign w_step_x   = (w_e2 >= $signed({r_dy[15], r_dy}));
  assign w_step_y   = (w_e2 <= $signed({r_dx[15], r_dx}));
  assign w_err_next = r_err + (w_step_x ? r_dy : 16'sd0) + (w_step_y ? r_dx : 16'sd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_line_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_intensity == 4'd0) begin
          w_state_next = S_IDLE;
          w_line_done  = 1'b1;
        end else begin
          w_state_next = S_DRAW;
        end
      end
      S_DRAW: begin
        if (w_advance && w_at_end) begin
          w_state_next = S_IDLE;
          w_line_done  = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_x1         <= '0;
      r_y1         <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_err        <= '0;
      r_sx_neg     <= 1'b0;
      r_sy_neg     <= 1'b0;
      r_intensity  <= '0;
      r_lines_done <= '0;
    end else begin
      if (w_pop) begin
        r_x         <= {{3{bus.qStartX[12]}}, bus.qStartX};
        r_y         <= {{3{bus.qStartY[12]}}, bus.qStartY};
        r_x1        <= {{3{bus.qEndX[12]}}, bus.qEndX};
        r_y1        <= {{3{bus.qEndY[12]}}, bus.qEndY};
        r_intensity <= bus.qIntensity;
      end

      if (r_state == S_SETUP) begin
        r_dx     <= w_abs_x;
        r_dy     <= -w_abs_y;
        r_err    <= w_abs_x - w_abs_y;
        r_sx_neg <= (r_x >= r_x1);
        r_sy_neg <= (r_y >= r_y1);
      end

      if (w_advance && !w_at_end) begin
        r_err <= w_err_next;
        if (w_step_x) begin
          r_x <= r_x + (r_sx_neg ? -16'sd1 : 16'sd1);
        end
        if (w_step_y) begin
          r_y <= r_y + (r_sy_neg ? -16'sd1 : 16'sd1);
        end
      end

      if (w_line_done) begin
        r_lines_done <= r_lines_done + 16'd1;
      end
    end
  end

  // Pixel fields are zeroed whenever no request is presented.
  assign bus.qRead        = w_pop;
  assign bus.pixValid     = w_pix_valid;
  assign bus.pixX         = w_pix_valid ? w_raster_x[9:0] : 10'd0;
  assign bus.pixY         = w_pix_valid ? w_raster_y[9:0] : 10'd0;
  assign bus.pixIntensity = w_pix_valid ? r_intensity : 4'd0;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.linesDone    = r_lines_done;

endmodule
`default_nettype wire

// File: tb/tb_vector_rasterizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_rasterizer
// Brief    : Scoreboard bench: queue model + Bresenham reference, randomized.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_rasterizer;
  localparam int HRES = 640;
  localparam int VRES = 480;

  typedef struct {
    int x0; int y0; int x1; int y1; int inten; int id;
  } seg_t;

  typedef struct {
    int x; int y; int inten; int id; int skip; bit first; bit last;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_rasterizer_if bus();

  vector_rasterizer #(.HRES(HRES), .VRES(VRES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seg_t seg_q[$];
  pix_t exp_q[$];
  int   nchk = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   pop_cycle = 0;
  int   last_acc_cycle = 0;
  int   inflight_id = -1;
  int   acc_total = 0;
  int   exp_lines = 0;
  int   next_id = 0;
  int   ready_mode = 0;
  int   rk = 0;
  bit   pop_req = 1'b0;
  bit   prev_hold = 1'b0;
  bit   prev_qread = 1'b0;
  bit   after_last = 1'b0;
  logic [9:0] hx, hy;
  logic [3:0] hi;

  task automatic chk(input string name, input longint act, input longint req);
    nchk++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: textbook Bresenham over the segment, then map and clip each point.
  task automatic push_seg(input int x0, input int y0, input int x1, input int y1, input int inten);
    seg_t s;
    pix_t p;
    int x, y, dx, dy, err, e2, sx, sy, skip, rx, ry;
    bit seen, vis, done;
    s = '{x0, y0, x1, y1, inten, next_id};
    seg_q.push_back(s);
    exp_lines++;
    if (inten != 0) begin
      x = x0; y = y0;
      dx = (x1 > x0) ? x1 - x0 : x0 - x1;
      dy = (y1 > y0) ? y0 - y1 : y1 - y0;
      err = dx + dy;
      sx = (x0 < x1) ? 1 : -1;
      sy = (y0 < y1) ? 1 : -1;
      skip = 0; seen = 0;
      forever begin
        rx = x + HRES / 2;
        ry = VRES / 2 - 1 - y;
        vis = (rx >= 0) && (rx < HRES) && (ry >= 0) && (ry < VRES);
        done = (x == x1) && (y == y1);
        if (vis) begin
          p = '{rx, ry, inten, next_id, skip, !seen, done};
          exp_q.push_back(p);
          seen = 1; skip = 0;
        end else begin
          skip++;
        end
        if (done) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
      end
    end
    next_id++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(seg_q.size() == 0 && !pop_req && !bus.busy && exp_q.size() == 0) && n < 5000);
    chk("drain_in_time", longint'(n < 5000), 1);
    chk("pixels_outstanding", exp_q.size(), 0);
    chk("lines_done", bus.linesDone, exp_lines % 65536);
  endtask

  // Queue model: presents the head, pops one cycle after qRead is seen.
  initial begin
    bus.qEmpty = 1'b1;
    bus.qStartX = '0; bus.qStartY = '0; bus.qEndX = '0; bus.qEndY = '0;
    bus.qIntensity = '0;
    forever begin
      @(posedge clk); #2;
      if (pop_req) begin
        if (seg_q.size() > 0) seg_q.delete(0);
        pop_req = 1'b0;
      end
      if (seg_q.size() > 0) begin
        bus.qEmpty     = 1'b0;
        bus.qStartX    = 13'(seg_q[0].x0);
        bus.qStartY    = 13'(seg_q[0].y0);
        bus.qEndX      = 13'(seg_q[0].x1);
        bus.qEndY      = 13'(seg_q[0].y1);
        bus.qIntensity = 4'(seg_q[0].inten);
      end else begin
        bus.qEmpty = 1'b1;
      end
    end
  end

  initial begin
    bus.pixReady = 1'b1;
    forever begin
      @(posedge clk); #1;
      rk++;
      case (ready_mode)
        1:       bus.pixReady = ((rk % 4) == 0) || ((rk % 4) == 3);
        2:       bus.pixReady = ($urandom_range(0, 2) != 0);
        default: bus.pixReady = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    pix_t p;
    forever begin
      @(negedge clk);
      cyc++;
      if (after_last && !rst) begin
        chk("idle_after_last", bus.busy, 0);
        chk("qread_after_last", bus.qRead, longint'(!bus.qEmpty));
      end
      after_last = 1'b0;
      if (bus.qRead) begin
        chk("qread_legal", {bus.qEmpty, prev_qread}, 0);
        if (seg_q.size() > 0) inflight_id = seg_q[0].id;
        pop_req = 1'b1;
        pop_cycle = cyc;
      end
      if (prev_hold) begin
        chk("stall_valid", bus.pixValid, 1);
        chk("stall_x", bus.pixX, hx);
        chk("stall_y", bus.pixY, hy);
        chk("stall_int", bus.pixIntensity, hi);
      end else if (bus.pixValid) begin
        chk("pixel_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          if (exp_q[0].first) chk("first_latency", cyc - pop_cycle, 2 + exp_q[0].skip);
          else                chk("pixel_cadence", cyc - last_acc_cycle, 1 + exp_q[0].skip);
        end
      end
      if (bus.pixValid && bus.pixReady && exp_q.size() > 0) begin
        p = exp_q.pop_front();
        chk("pix_x", bus.pixX, p.x);
        chk("pix_y", bus.pixY, p.y);
        chk("pix_int", bus.pixIntensity, p.inten);
        acc_total++;
        last_acc_cycle = cyc;
        after_last = p.last;
      end
      prev_hold  = bus.pixValid && !bus.pixReady;
      hx = bus.pixX; hy = bus.pixY; hi = bus.pixIntensity;
      prev_qread = bus.qRead;
      if (rst) begin
        for (int i = exp_q.size() - 1; i >= 0; i--)
          if (exp_q[i].id == inflight_id) exp_q.delete(i);
        prev_hold = 1'b0; prev_qread = 1'b0; after_last = 1'b0; inflight_id = -1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, x0, y0, x1, y1, inten;
    rst = 1'b1;
    push_seg(0, 0, 3, 0, 5);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_qread", bus.qRead, 0);
    chk("rst_pixvalid", bus.pixValid, 0);
    chk("rst_pixx", bus.pixX, 0);
    chk("rst_pixy", bus.pixY, 0);
    chk("rst_pixint", bus.pixIntensity, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_lines", bus.linesDone, 0);
    rst = 1'b0;
    wait_idle();

    push_seg(0, 0, -2, 2, 9);
    push_seg(0, 0, 0, 0, 3);
    wait_idle();

    ready_mode = 1;
    push_seg(0, 0, 5, 1, 7);
    wait_idle();
    ready_mode = 0;

    push_seg(-330, 0, -315, 0, 4);
    push_seg(1, 1, 5, 5, 0);
    wait_idle();

    push_seg(10, 10, 14, 12, 1);
    push_seg(-5, -5, -9, -1, 15);
    push_seg(300, 200, 330, 250, 8);
    wait_idle();

    push_seg(319, 239, 322, 242, 2);
    push_seg(-322, -242, -318, -238, 6);
    push_seg(4090, -4096, 4095, -4090, 11);
    wait_idle();

    base = acc_total;
    push_seg(0, 0, 9, 0, 6);
    push_seg(0, 5, 2, 5, 2);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(bus.pixValid && acc_total == base + 2) && n < 100);
    chk("third_pixel_reached", longint'(n < 100), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_pixvalid", bus.pixValid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_lines", bus.linesDone, 0);
    exp_lines = seg_q.size();
    wait_idle();

    ready_mode = 2;
    for (int k = 0; k < 40; k++) begin
      x0 = int'($urandom_range(0, 900)) - 450;
      y0 = int'($urandom_range(0, 700)) - 350;
      x1 = x0 + int'($urandom_range(0, 80)) - 40;
      y1 = y0 + int'($urandom_range(0, 80)) - 40;
      inten = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
      push_seg(x0, y0, x1, y1, inten);
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
      end else begin
        repeat ($urandom_range(0, 20)) begin @(posedge clk); #1; end
      end
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule
`default_nettype wire
